// File: rtl/dyn_field_extract_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dyn_field_extract_pkg
// Brief    : Shared types for the dynamic bit-field extractor: input word
//            layout, skid-buffer state encoding and position-width helper.
// Revision : 1.0 - initial release
// ============================================================================
package dyn_field_extract_pkg;

    localparam int c_W_DATA = 16;

    // Position fields are one bit wider than an index so W_DATA itself is representable
    function automatic int calc_w_pos(input int w_data);
        return $clog2(w_data) + 1;
    endfunction

    localparam int c_W_POS = calc_w_pos(c_W_DATA);

    typedef struct packed {
        logic [c_W_POS-1:0]  high_pos;
        logic [c_W_POS-1:0]  low_pos;
        logic [c_W_DATA-1:0] data;
    } din_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/dti_s_if.sv
`default_nettype none
// ============================================================================
// Module   : dti_s_if
// Brief    : Valid/ready streaming interface carrying a data word and an
//            end-of-transfer marker.
// Revision : 1.0 - initial release
// ============================================================================
interface dti_s_if #(
    parameter int W_DATA = 16
);
    logic [W_DATA-1:0] data;
    logic              eot;
    logic              dvalid;
    logic              dready;

    modport producer (output data, output eot, output dvalid, input dready);
    modport consumer (input data, input eot, input dvalid, output dready);
endinterface
`default_nettype wire

// File: rtl/dyn_field_mask.sv
`default_nettype none
// ============================================================================
// Module   : dyn_field_mask
// Brief    : Combinational field extractor: keeps data bits low..high (high
//            clamped to the word), optionally shifted down to bit 0.
// Revision : 1.0 - initial release
// ============================================================================
module dyn_field_mask
    import dyn_field_extract_pkg::*;
#(
    parameter int  W_DATA = 16,
    parameter int  ALIGN  = 0,
    localparam int W_POS  = calc_w_pos(W_DATA)
) (
    input  wire [W_DATA-1:0] i_data,
    input  wire [W_POS-1:0]  i_low_pos,
    input  wire [W_POS-1:0]  i_high_pos,
    output logic [W_DATA-1:0] o_field,
    output logic              o_invalid
);

    localparam logic [W_POS-1:0] c_LAST  = W_POS'(W_DATA - 1);
    localparam logic [W_POS-1:0] c_LIMIT = W_POS'(W_DATA);

    logic [W_POS-1:0]  w_high;
    logic [W_DATA-1:0] w_lo_mask;
    logic [W_DATA-1:0] w_hi_mask;
    logic [W_DATA-1:0] w_field;

    assign w_high = (i_high_pos > c_LAST) ? c_LAST : i_high_pos;

    // Shifts of W_POS width saturate to zero, so low >= W_DATA empties the mask
    assign w_lo_mask = {W_DATA{1'b1}} << i_low_pos;
    assign w_hi_mask = {W_DATA{1'b1}} >> (c_LAST - w_high);
    assign w_field   = i_data & w_lo_mask & w_hi_mask;

    assign o_invalid = (i_low_pos >= c_LIMIT) || (i_low_pos > w_high);

    if (ALIGN == 1) begin : g_align
        assign o_field = w_field >> i_low_pos;
    end else begin : g_in_place
        assign o_field = w_field;
    end

endmodule
`default_nettype wire

// File: rtl/dyn_field_extract.sv
`default_nettype none
// ============================================================================
// Module   : dyn_field_extract
// Brief    : Extracts a run-time selected bit field from each streamed word
//            into a registered 2-entry skid buffer. Optional sticky range_err
//            output enabled by macro DYN_FIELD_EXTRACT_ERR_EN.
// Revision : 1.0 - initial release
// ============================================================================
module dyn_field_extract
    import dyn_field_extract_pkg::*;
#(
    parameter int W_DATA = c_W_DATA,
    parameter int ALIGN  = 0
) (
    input  wire        clk,
    input  wire        rst,
    dti_s_if.consumer  din,
    dti_s_if.producer  dout
`ifdef DYN_FIELD_EXTRACT_ERR_EN
    ,
    output logic       range_err
`endif
);

    localparam int W_POS   = calc_w_pos(W_DATA);
    localparam int c_W_DIN = W_DATA + 2 * W_POS;

    if (W_DATA < 2) begin : g_bad_width
        $fatal(1, "dyn_field_extract: W_DATA must be at least 2");
    end
    if ($bits(din.data) != c_W_DIN) begin : g_bad_din
        $fatal(1, "dyn_field_extract: din width must be W_DATA+2*W_POS");
    end
    if ($bits(dout.data) != W_DATA) begin : g_bad_dout
        $fatal(1, "dyn_field_extract: dout width must be W_DATA");
    end
    if (ALIGN != 0 && ALIGN != 1) begin : g_bad_align
        $fatal(1, "dyn_field_extract: ALIGN must be 0 or 1");
    end

    typedef struct packed {
        logic [W_POS-1:0]  high_pos;
        logic [W_POS-1:0]  low_pos;
        logic [W_DATA-1:0] data;
    } din_word_t;

    din_word_t         w_din;
    logic [W_DATA-1:0] w_field;
    logic [W_DATA-1:0] w_result;
    logic              w_invalid;
    logic              w_in_xfer;
    logic              w_out_xfer;

    state_t            r_state;
    logic              r_in_ready;
    logic              r_out_valid;
    logic [W_DATA-1:0] r_out_data;
    logic              r_out_eot;
    logic [W_DATA-1:0] r_skid_data;
    logic              r_skid_eot;

    assign w_din = din.data;

    dyn_field_mask #(
        .W_DATA (W_DATA),
        .ALIGN  (ALIGN)
    ) u_mask (
        .i_data     (w_din.data),
        .i_low_pos  (w_din.low_pos),
        .i_high_pos (w_din.high_pos),
        .o_field    (w_field),
        .o_invalid  (w_invalid)
    );

    // Invalid ranges always yield zero, independent of how the mask degenerates
    assign w_result   = w_invalid ? '0 : w_field;
    assign w_in_xfer  = din.dvalid && r_in_ready;
    assign w_out_xfer = r_out_valid && dout.dready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= EMPTY;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_eot   <= 1'b0;
            r_skid_data <= '0;
            r_skid_eot  <= 1'b0;
        end else begin
            case (r_state)
                EMPTY: begin
                    r_in_ready <= 1'b1;
                    if (w_in_xfer) begin
                        r_out_data  <= w_result;
                        r_out_eot   <= din.eot;
                        r_out_valid <= 1'b1;
                        r_state     <= ONE;
                    end
                end
                ONE: begin
                    if (w_in_xfer && w_out_xfer) begin
                        r_out_data <= w_result;
                        r_out_eot  <= din.eot;
                    end else if (w_in_xfer) begin
                        r_skid_data <= w_result;
                        r_skid_eot  <= din.eot;
                        r_in_ready  <= 1'b0;
                        r_state     <= FULL;
                    end else if (w_out_xfer) begin
                        r_out_valid <= 1'b0;
                        r_state     <= EMPTY;
                    end
                end
                FULL: begin
                    if (w_out_xfer) begin
                        r_out_data <= r_skid_data;
                        r_out_eot  <= r_skid_eot;
                        r_in_ready <= 1'b1;
                        r_state    <= ONE;
                    end
                end
                default: begin
                    r_state     <= EMPTY;
                    r_in_ready  <= 1'b0;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign din.dready  = r_in_ready;
    assign dout.dvalid = r_out_valid;
    assign dout.data   = r_out_data;
    assign dout.eot    = r_out_eot;

`ifdef DYN_FIELD_EXTRACT_ERR_EN
    logic r_range_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_range_err <= 1'b0;
        end else if (w_in_xfer && w_invalid) begin
            r_range_err <= 1'b1;
        end
    end

    assign range_err = r_range_err;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dyn_field_extract.sv
`default_nettype none
// ============================================================================
// Module   : tb_dyn_field_extract
// Brief    : Scoreboard bench driving one stream into an ALIGN=0 and an
//            ALIGN=1 instance; a monitor checks every delivered word.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dyn_field_extract;
    import dyn_field_extract_pkg::*;

    localparam int W_DATA = 16;
    localparam int W_IN   = W_DATA + 2 * c_W_POS;

    typedef struct packed {
        logic [15:0] data;
        logic        eot;
    } exp_t;

    typedef struct packed {
        logic [15:0] d;
        logic [4:0]  hi;
        logic [4:0]  lo;
        logic [15:0] x0;
        logic [15:0] x1;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    dti_s_if #(.W_DATA(W_IN))   din0 ();
    dti_s_if #(.W_DATA(W_IN))   din1 ();
    dti_s_if #(.W_DATA(W_DATA)) dout0 ();
    dti_s_if #(.W_DATA(W_DATA)) dout1 ();
`ifdef DYN_FIELD_EXTRACT_ERR_EN
    logic err0;
    logic err1;
`endif

    dyn_field_extract #(.W_DATA(W_DATA), .ALIGN(0)) u_dut0 (
        .clk  (clk),
        .rst  (rst),
        .din  (din0),
        .dout (dout0)
`ifdef DYN_FIELD_EXTRACT_ERR_EN
        ,
        .range_err (err0)
`endif
    );

    dyn_field_extract #(.W_DATA(W_DATA), .ALIGN(1)) u_dut1 (
        .clk  (clk),
        .rst  (rst),
        .din  (din1),
        .dout (dout1)
`ifdef DYN_FIELD_EXTRACT_ERR_EN
        ,
        .range_err (err1)
`endif
    );

    exp_t q0[$];
    exp_t q1[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   n_out0  = 0;
    int   n_stall = 0;
    int   last_out_edge = 0;
    int   last_acc_edge = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_out(input int p, input logic [15:0] d, input logic e);
        exp_t x;
        logic empty;
        empty = (p == 0) ? (q0.size() == 0) : (q1.size() == 0);
        n_tests++;
        if (empty) begin
            n_fail++;
            $display("FAIL out%0d_unexpected: got data 0x%04h eot %0b, required no output", p, d, e);
        end else begin
            if (p == 0) x = q0.pop_front();
            else        x = q1.pop_front();
            if (d !== x.data || e !== x.eot) begin
                n_fail++;
                $display("FAIL out%0d_word: got data 0x%04h eot %0b, required data 0x%04h eot %0b",
                         p, d, e, x.data, x.eot);
            end
        end
    endtask

    initial begin : p_monitor
        forever begin
            @(negedge clk);
            if (!rst && dout0.dvalid && dout0.dready) begin
                check_out(0, dout0.data, dout0.eot);
                n_out0++;
                last_out_edge = cyc + 1;
            end
            if (!rst && dout1.dvalid && dout1.dready) begin
                check_out(1, dout1.data, dout1.eot);
            end
        end
    end

    // Called #1 after a rising edge; returns #1 after the accepting edge
    task automatic send(input logic [15:0] d, input logic [4:0] hi, input logic [4:0] lo,
                        input logic e, input logic [15:0] x0, input logic [15:0] x1);
        din_t w;
        int   waited;
        waited     = 0;
        w.data     = d;
        w.high_pos = hi;
        w.low_pos  = lo;
        din0.data  = w;
        din1.data  = w;
        din0.eot   = e;
        din1.eot   = e;
        din0.dvalid = 1'b1;
        din1.dvalid = 1'b1;
        while (!din0.dready) begin
            if (waited == 200) begin
                n_tests++;
                n_fail++;
                $display("FAIL send_timeout: word 0x%04h not accepted, required acceptance", d);
                din0.dvalid = 1'b0;
                din1.dvalid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
            waited++;
            n_stall++;
        end
        q0.push_back('{data: x0, eot: e});
        q1.push_back('{data: x1, eot: e});
        last_acc_edge = cyc + 1;
        @(posedge clk);
        #1;
        din0.dvalid = 1'b0;
        din1.dvalid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        n_tests++;
        if (q0.size() != 0 || q1.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain: %0d/%0d words pending, required 0", tag, q0.size(), q1.size());
        end
    endtask

    task automatic set_out_ready(input logic r);
        dout0.dready = r;
        dout1.dready = r;
    endtask

    initial begin : p_watchdog
        #300000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1, "watchdog expired");
    end

    vec_t vecs [7];
    bit   bp_done;

    initial begin : p_main
        int first_acc;
        int o0;
        int s0;
        int n;

        vecs = '{
            '{16'hABCD, 5'd11, 5'd4,  16'h0BC0, 16'h00BC},
            '{16'hABCD, 5'd20, 5'd12, 16'hA000, 16'h000A},
            '{16'h1234, 5'd15, 5'd0,  16'h1234, 16'h1234},
            '{16'h8001, 5'd0,  5'd0,  16'h0001, 16'h0001},
            '{16'h8001, 5'd15, 5'd15, 16'h8000, 16'h0001},
            '{16'h5A5A, 5'd7,  5'd3,  16'h0058, 16'h000B},
            '{16'hFFFF, 5'd16, 5'd15, 16'h8000, 16'h0001}
        };
        din0.dvalid = 1'b0;
        din1.dvalid = 1'b0;
        din0.eot    = 1'b0;
        din1.eot    = 1'b0;
        din0.data   = '0;
        din1.data   = '0;
        set_out_ready(1'b0);

        // Reset state
        #1 rst = 1'b1;
        #1;
        check("reset_dvalid", 32'(dout0.dvalid), 32'd0);
        check("reset_dready", 32'(din0.dready), 32'd0);
        check("reset_data",   32'(dout0.data), 32'd0);
        check("reset_eot",    32'(dout0.eot), 32'd0);
`ifdef DYN_FIELD_EXTRACT_ERR_EN
        check("reset_range_err", 32'(err0), 32'd0);
`endif
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("dready_before_edge", 32'(din0.dready), 32'd0);
        @(posedge clk);
        #1;
        check("dready_first_edge", 32'(din0.dready), 32'd1);

        // Basic extraction and one-cycle latency
        set_out_ready(1'b1);
        send(16'hFFFF, 5'd11, 5'd4, 1'b0, 16'h0FF0, 16'h00FF);
        check("latency_dvalid", 32'(dout0.dvalid), 32'd1);
        check("latency_data0",  32'(dout0.data), 32'h0FF0);
        check("latency_data1",  32'(dout1.data), 32'h00FF);
        for (int i = 0; i < 7; i++) begin
            send(vecs[i].d, vecs[i].hi, vecs[i].lo, 1'b0, vecs[i].x0, vecs[i].x1);
        end
`ifdef DYN_FIELD_EXTRACT_ERR_EN
        check("range_err_clear", 32'(err0), 32'd0);
`endif
        send(16'hABCD, 5'd3, 5'd9, 1'b0, 16'h0000, 16'h0000);
`ifdef DYN_FIELD_EXTRACT_ERR_EN
        check("range_err_set0", 32'(err0), 32'd1);
        check("range_err_set1", 32'(err1), 32'd1);
`endif
        send(16'hFFFF, 5'd31, 5'd16, 1'b1, 16'h0000, 16'h0000);
        drain("vectors");

        // Backpressure: two accepted, then input stalls until output drains
        set_out_ready(1'b0);
        send(16'h1234, 5'd15, 5'd8, 1'b0, 16'h1200, 16'h0012);
        send(16'h5678, 5'd15, 5'd8, 1'b0, 16'h5600, 16'h0056);
        check("bp_dready_low", 32'(din0.dready), 32'd0);
        bp_done = 1'b0;
        fork
            begin
                send(16'h9ABC, 5'd15, 5'd8, 1'b0, 16'h9A00, 16'h009A);
                send(16'hDEF0, 5'd15, 5'd8, 1'b1, 16'hDE00, 16'h00DE);
                bp_done = 1'b1;
            end
        join_none
        repeat (3) @(posedge clk);
        #1;
        check("bp_dready_held", 32'(din0.dready), 32'd0);
        check("bp_accepted",    32'(q0.size()), 32'd2);
        check("bp_hold_data0",  32'(dout0.data), 32'h1200);
        check("bp_hold_data1",  32'(dout1.data), 32'h0012);
        set_out_ready(1'b1);
        n = 0;
        while (!bp_done && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("bp_sender_done", 32'(bp_done), 32'd1);
        drain("backpressure");
`ifdef DYN_FIELD_EXTRACT_ERR_EN
        check("range_err_sticky", 32'(err0), 32'd1);
`endif

        // Full throughput: 100 words, no bubbles
        o0 = n_out0;
        s0 = n_stall;
        send(16'h0003, 5'd15, 5'd0, 1'b0, 16'h0003, 16'h0003);
        first_acc = last_acc_edge;
        for (int i = 1; i < 100; i++) begin
            send(16'(i * 16'h0101 + 3), 5'd15, 5'd0, (i == 99),
                 16'(i * 16'h0101 + 3), 16'(i * 16'h0101 + 3));
        end
        n = 0;
        while ((n_out0 - o0) < 100 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("tp_outputs", 32'(n_out0 - o0), 32'd100);
        check("tp_stalls",  32'(n_stall - s0), 32'd0);
        check("tp_span",    32'(last_out_edge - first_acc), 32'd100);
        drain("throughput");

        // Asynchronous reset while full
        set_out_ready(1'b0);
        send(16'h0F0F, 5'd15, 5'd0, 1'b0, 16'h0F0F, 16'h0F0F);
        send(16'h0F0F, 5'd15, 5'd0, 1'b1, 16'h0F0F, 16'h0F0F);
        check("full_dvalid", 32'(dout0.dvalid), 32'd1);
        check("full_dready", 32'(din0.dready), 32'd0);
        #2 rst = 1'b1;
        #1;
        check("async_rst_dvalid", 32'(dout0.dvalid), 32'd0);
        check("async_rst_dready", 32'(din0.dready), 32'd0);
        check("async_rst_data",   32'(dout0.data), 32'd0);
`ifdef DYN_FIELD_EXTRACT_ERR_EN
        check("async_rst_range_err", 32'(err0), 32'd0);
`endif
        q0.delete();
        q1.delete();
        set_out_ready(1'b1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("post_rst_idle", 32'(dout0.dvalid), 32'd0);
        send(16'hBEEF, 5'd15, 5'd4, 1'b1, 16'hBEE0, 16'h0BEE);
        drain("post_reset");

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dyn_field_extract.md
DYN_FIELD_EXTRACT -- requirements
Module: dyn_field_extract

Interface
REQ-001 SHALL have parameter W_DATA, default 16, payload data width in bits (>=2).
REQ-002 SHALL have parameter ALIGN, default 0; 0 = mask field in place, 1 = mask field and shift it down to bit 0.
REQ-003 SHALL derive W_POS = $clog2(W_DATA)+1 for each position field.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port din  dti_s_if.consumer  W_DATA+2*W_POS  packed {high_pos, low_pos, data}, MSB first; with eot, dvalid, dready.
REQ-007 SHALL have port dout  dti_s_if.producer  W_DATA  extracted field; with eot, dvalid, dready.
REQ-008 SHALL, with the macro of REQ-027 defined, have port range_err  output  1  sticky invalid-range flag.

Function
REQ-009 SHALL set output bit i = din.data[i] when low_pos <= i <= high_pos, else 0 (ALIGN=0).
REQ-010 SHALL, for ALIGN=1, output the REQ-009 result logically right-shifted by low_pos, zero-filled.
REQ-011 SHALL treat high_pos >= W_DATA as W_DATA-1 (clamp); SHALL output all zeros when low_pos >= W_DATA.
REQ-012 SHALL output all zeros when low_pos > high_pos (after clamp); this is an invalid range.
REQ-013 SHALL compare positions unsigned, at W_POS bits, with no truncation.
REQ-014 SHALL carry din.eot unchanged alongside its data word.
REQ-015 SHALL register results in a 2-entry skid buffer; latency din transfer -> dout.dvalid is exactly 1 cycle.
REQ-016 SHALL drive din.dready from a register: 1 in states EMPTY and ONE, 0 in FULL; no combinational path dout.dready -> din.dready.
REQ-017 SHALL use states EMPTY, ONE, FULL: EMPTY->ONE on in-transfer; ONE->FULL on in-transfer without out-transfer; ONE->EMPTY on out-transfer without in-transfer; ONE stays ONE on simultaneous in/out; FULL->ONE on out-transfer.
REQ-018 SHALL never accept input in FULL; SHALL sustain one transfer per cycle while dout.dready=1.
REQ-019 SHALL hold dout.data, dout.eot stable while dout.dvalid=1 and dout.dready=0.
REQ-020 SHALL deliver words in acceptance order, none dropped or duplicated.
REQ-021 SHALL, with REQ-027 enabled, set range_err the cycle after accepting an invalid-range word (REQ-012 or low_pos >= W_DATA); clear only by reset.

Reset
REQ-022 SHALL, on rst assertion, immediately enter EMPTY with dout.dvalid=0, din.dready=0, dout.data=0, dout.eot=0, range_err=0.
REQ-023 SHALL raise din.dready on the first clock edge after rst deasserts.
REQ-024 SHALL discard buffered words when reset is asserted mid-operation; no output after reset until new input is accepted.

Configuration
REQ-025 SHALL abort elaboration with $fatal if din width != W_DATA+2*W_POS or dout width != W_DATA.
REQ-026 SHALL abort elaboration with $fatal if ALIGN is not 0 or 1.
REQ-027 SHALL compile the range_err port and its logic only when DYN_FIELD_EXTRACT_ERR_EN is defined; without it neither port nor logic exists, and REQ-009..REQ-024 are unchanged.

Structure
REQ-028 SHALL place the din_t packed struct (high_pos, low_pos, data), parameterised via W_DATA, and the state enum in package dyn_field_extract_pkg.
REQ-029 SHALL implement the extraction as combinational sub-module dyn_field_mask (params W_DATA, ALIGN), instantiated once ahead of the skid buffer.

Verification
REQ-030 SHALL test W_DATA=16, ALIGN=0: data=0xFFFF, high=11, low=4, dout.dready=1 -> next cycle dout.data=0x0FF0, dvalid=1.
REQ-031 SHALL test ALIGN=1: data=0xABCD, high=11, low=4 -> dout.data=0x00BC; high=20 (clamp), low=12 -> 0x000A.
REQ-032 SHALL test invalid range: high=3, low=9 -> dout.data=0x0000; range_err=1 next cycle and stays 1 (ERR_EN defined).
REQ-033 SHALL test backpressure: 4-word burst with eot on word 4, dout.dready=0 -> din.dready=0 after 2 accepts; release -> all 4 delivered in order, eot only on word 4.
REQ-034 SHALL test full throughput: 100 back-to-back words, dout.dready=1 -> 100 outputs in 101 cycles, no bubbles.
REQ-035 SHALL test async reset while FULL -> dvalid and dready drop without a clock edge; first post-reset output is a newly sent word.
